// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer
// Frame controller for a free-running FIR datapath. Feeds one sample per
// clock, pads every frame with TAPS-1 zeros so the whole convolution tail
// comes out, and tags the FIR outputs with valid/last after the pipeline delay.
module fir_frame_sequencer #(
  parameter int DW      = 16,
  parameter int OW      = 32,
  parameter int TAPS    = 17,
  parameter int FIR_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             s_last,
  output logic [DW-1:0]    fir_in,
  input  logic [OW-1:0]    fir_out,
  output logic             m_valid,
  output logic [OW-1:0]    m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] frame_len,
  output logic             underrun,
  output logic             busy
);

  // Counter widths: flush counter reaches TAPS-1, drain counter reaches FIR_LAT.
  localparam int FL_W = $clog2(TAPS) + 1;
  localparam int DR_W = $clog2(FIR_LAT + 1) + 1;

  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(TAPS - 2);
  localparam logic [DR_W-1:0]  DR_LAST = DR_W'(FIR_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    fir_in_reg, fir_in_next;
  logic             tag_reg, tag_next;
  logic             tag_last_reg, tag_last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] frame_len_reg, frame_len_next;
  logic             underrun_reg, underrun_next;
  logic [FL_W-1:0]  flush_cnt_reg, flush_cnt_next;
  logic [DR_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic             ready_en_reg;
  logic             ready_c;

  // Tag pipe: one stage per clock of FIR latency.
  logic [FIR_LAT-1:0] tag_pipe_reg, tag_shift;
  logic [FIR_LAT-1:0] last_pipe_reg, last_shift;

  logic          m_valid_reg;
  logic          m_last_reg;
  logic [OW-1:0] m_data_reg;

  // Saturating increment of the frame sample counter.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Hold off acceptance for the first clock after reset release so that
  // s_ready reads 0 while rst is asserted, like every other output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
    end
  end

  // FSM state and datapath-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      fir_in_reg    <= '0;
      tag_reg       <= 1'b0;
      tag_last_reg  <= 1'b0;
      cnt_reg       <= '0;
      frame_len_reg <= '0;
      underrun_reg  <= 1'b0;
      flush_cnt_reg <= '0;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fir_in_reg    <= fir_in_next;
      tag_reg       <= tag_next;
      tag_last_reg  <= tag_last_next;
      cnt_reg       <= cnt_next;
      frame_len_reg <= frame_len_next;
      underrun_reg  <= underrun_next;
      flush_cnt_reg <= flush_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // Next-state and next-register logic; the FIR never stalls, so every
  // state drives a defined sample (zero unless a real sample is accepted).
  always_comb begin
    state_next     = state_reg;
    fir_in_next    = '0;
    tag_next       = 1'b0;
    tag_last_next  = 1'b0;
    cnt_next       = cnt_reg;
    frame_len_next = frame_len_reg;
    underrun_next  = 1'b0;
    flush_cnt_next = flush_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    ready_c        = 1'b0;

    case (state_reg)
      IDLE: begin
        ready_c        = ready_en_reg;
        flush_cnt_next = '0;
        drain_cnt_next = '0;
        if (s_valid && ready_en_reg) begin
          fir_in_next = s_data;
          tag_next    = 1'b1;
          cnt_next    = CNT_W'(1);
          if (s_last) begin
            frame_len_next = CNT_W'(1);
            state_next     = FLUSH;
          end else begin
            state_next = STREAM;
          end
        end
      end

      STREAM: begin
        ready_c  = 1'b1;
        tag_next = 1'b1;
        cnt_next = cnt_inc;
        if (s_valid) begin
          fir_in_next = s_data;
          if (s_last) begin
            frame_len_next = cnt_inc;
            state_next     = FLUSH;
          end
        end else begin
          // Source gap mid-frame: a zero goes into the filter and counts
          // as a sample of the frame.
          underrun_next = 1'b1;
        end
      end

      FLUSH: begin
        tag_next       = 1'b1;
        flush_cnt_next = flush_cnt_reg + FL_W'(1);
        if (flush_cnt_reg == FL_LAST) begin
          tag_last_next = 1'b1;
          state_next    = DRAIN;
        end
      end

      DRAIN: begin
        drain_cnt_next = drain_cnt_reg + DR_W'(1);
        if (drain_cnt_reg == DR_LAST) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift-in vectors for the tag pipe: stage 0 takes the tag registered
  // with fir_in, each later stage takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < FIR_LAT; gi++) begin : g_tag_pipe
      if (gi == 0) begin : g_head
        assign tag_shift[gi]  = tag_reg;
        assign last_shift[gi] = tag_last_reg;
      end else begin : g_body
        assign tag_shift[gi]  = tag_pipe_reg[gi-1];
        assign last_shift[gi] = last_pipe_reg[gi-1];
      end
    end
  endgenerate

  // Delay {tag, tag_last} by the FIR latency so they line up with fir_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_pipe_reg  <= '0;
      last_pipe_reg <= '0;
    end else begin
      tag_pipe_reg  <= tag_shift;
      last_pipe_reg <= last_shift;
    end
  end

  // Output stage: register the FIR result together with its tags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      m_valid_reg <= tag_pipe_reg[FIR_LAT-1];
      m_last_reg  <= last_pipe_reg[FIR_LAT-1];
      m_data_reg  <= fir_out;
    end
  end

  assign s_ready   = ready_c;
  assign fir_in    = fir_in_reg;
  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign m_data    = m_data_reg;
  assign frame_len = frame_len_reg;
  assign underrun  = underrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule
